// File: rtl/touch_key_led_array.sv
// Multi-channel touch-key front end: per-channel synchroniser, debouncer,
// edge qualifier, LED toggle register and optional long-press detector.
module touch_key_led_array #(
  parameter int unsigned NUM_KEYS          = 4,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned LONG_PRESS_CYCLES = 0,
  parameter int unsigned EDGE_MODE         = 0,
  parameter logic        LED_INIT          = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [NUM_KEYS-1:0] led_en,
  input  logic                clr,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_event,
  output logic [NUM_KEYS-1:0] long_press,
  output logic [NUM_KEYS-1:0] led
);

  localparam int unsigned    DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned    HW       = (LONG_PRESS_CYCLES > 0) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;
  localparam logic [HW-1:0]  HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0]  HOLD_PRE = HW'(LONG_PRESS_CYCLES - 1);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          db_cnt;
    logic                   s;
    logic                   level;
    logic                   event_q;
    logic                   led_q;
    logic                   accept;
    logic                   qualify;

    assign s = sync[SYNC_STAGES-1];

    // Acceptance of a new level and whether its direction counts as an event
    always_comb begin
      accept  = 1'b0;
      qualify = 1'b0;
      accept  = (s != level) && (db_cnt == DB_LAST);
      if (EDGE_MODE == 2)      qualify = 1'b1;
      else if (EDGE_MODE == 1) qualify = ~s;
      else                     qualify = s;
    end

    // Input synchroniser shift chain
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], key_in[k]};
    end

    // Debounce counter, debounced level and one-cycle event pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt  <= '0;
        level   <= 1'b0;
        event_q <= 1'b0;
      end else begin
        event_q <= accept & qualify;
        if (s == level) begin
          db_cnt <= '0;
        end else if (accept) begin
          level  <= s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end
    end

    // LED register: clear wins over a toggle on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           led_q <= LED_INIT;
      else if (clr)                         led_q <= LED_INIT;
      else if (accept && qualify && led_en[k]) led_q <= ~led_q;
    end

    if (LONG_PRESS_CYCLES > 0) begin : g_hold
      logic [HW-1:0] hold_cnt;
      logic          lp_q;

      // Hold counter saturates at its terminal value so the pulse fires once per press
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_cnt <= '0;
          lp_q     <= 1'b0;
        end else if (!level) begin
          hold_cnt <= '0;
          lp_q     <= 1'b0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + HW'(1);
          lp_q     <= (hold_cnt == HOLD_PRE);
        end else begin
          lp_q     <= 1'b0;
        end
      end

      assign long_press[k] = lp_q;
    end else begin : g_no_hold
      assign long_press[k] = 1'b0;
    end

    assign key_level[k] = level;
    assign key_event[k] = event_q;
    assign led[k]       = led_q;
  end

endmodule

// File: tb/tb_touch_key_led_array.sv
// Bench for touch_key_led_array: two instances (rising-edge and both-edge
// qualification) driven by shared directed and random stimulus, checked
// against a sample-history reference model.
module tb_touch_key_led_array;

  localparam int NK   = 2;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LP   = 10;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] led_en = 2'b11;
  logic          clr    = 1'b0;

  logic [NK-1:0] kl0, ke0, lp0, led0;
  logic [NK-1:0] kl2, ke2, lp2, led2;

  int tests  = 0;
  int fails  = 0;
  int lp_cnt = 0;

  // reference model state; index 0 = rising-edge instance, 1 = both-edge instance
  int n;
  bit raw  [NK][64];
  bit mlvl [2][NK];
  bit mled [2][NK];
  bit mevt [2][NK];
  bit mlp  [2][NK];
  int rise [2][NK];

  always #5 clk = ~clk;

  touch_key_led_array #(
    .NUM_KEYS(NK), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
    .LONG_PRESS_CYCLES(LP), .EDGE_MODE(0), .LED_INIT(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .led_en(led_en), .clr(clr),
    .key_level(kl0), .key_event(ke0), .long_press(lp0), .led(led0)
  );

  touch_key_led_array #(
    .NUM_KEYS(NK), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
    .LONG_PRESS_CYCLES(LP), .EDGE_MODE(2), .LED_INIT(1'b1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .led_en(led_en), .clr(clr),
    .key_level(kl2), .key_event(ke2), .long_press(lp2), .led(led2)
  );

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < 64; i++) raw[k][i] = 1'b0;
      for (int md = 0; md < 2; md++) begin
        mlvl[md][k] = 1'b0;
        mled[md][k] = 1'b1;
        mevt[md][k] = 1'b0;
        mlp[md][k]  = 1'b0;
        rise[md][k] = 0;
      end
    end
  endtask

  // synchronised sample the debouncer sees at edge m (zero before reset history)
  function automatic bit used_sample(int k, int m);
    if (m - SYNC >= 1) return raw[k][(m - SYNC) % 64];
    return 1'b0;
  endfunction

  // A level is accepted when the last DB samples seen all differ from it.
  task automatic model_step();
    bit prev, acc, q;
    n++;
    for (int k = 0; k < NK; k++) raw[k][n % 64] = key_in[k];
    for (int md = 0; md < 2; md++) begin
      for (int k = 0; k < NK; k++) begin
        prev = mlvl[md][k];
        acc  = 1'b1;
        for (int j = 0; j < DB; j++) begin
          if ((n - j) < 1 || used_sample(k, n - j) == prev) acc = 1'b0;
        end
        mlp[md][k]  = prev && ((n - rise[md][k]) == LP);
        mevt[md][k] = 1'b0;
        if (acc) begin
          mlvl[md][k] = !prev;
          q = (md == 0) ? mlvl[md][k] : 1'b1;
          mevt[md][k] = q;
          if (mlvl[md][k]) rise[md][k] = n;
          if (q && led_en[k]) mled[md][k] = !mled[md][k];
        end
        if (clr) mled[md][k] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at %0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NK-1:0] el, ee, ep, ed;
    for (int md = 0; md < 2; md++) begin
      for (int k = 0; k < NK; k++) begin
        el[k] = mlvl[md][k];
        ee[k] = mevt[md][k];
        ep[k] = mlp[md][k];
        ed[k] = mled[md][k];
      end
      if (md == 0) begin
        chk("m0_key_level", kl0, el);
        chk("m0_key_event", ke0, ee);
        chk("m0_long_press", lp0, ep);
        chk("m0_led", led0, ed);
      end else begin
        chk("m2_key_level", kl2, el);
        chk("m2_key_event", ke2, ee);
        chk("m2_long_press", lp2, ep);
        chk("m2_led", led2, ed);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (lp0[0] === 1'b1) lp_cnt++;
    check_all();
  endtask

  task automatic cycles(input int c);
    for (int i = 0; i < c; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    // 1: reset values
    do_reset();
    chk("t1_led_const", led0, 2'b11);

    // 2: rising-edge press held 30 cycles
    lp_cnt    = 0;
    key_in[0] = 1'b1;
    cycles(5);
    chk("t2_level_before", kl0, 2'b00);
    cycle();
    chk("t2_level_edge6", kl0, 2'b01);
    chk("t2_event_edge6", ke0, 2'b01);
    chk("t2_led_edge6", led0, 2'b10);
    cycles(24);
    chk("t2_led_after", led0, 2'b10);
    tests++;
    assert (lp_cnt == 1) else begin
      fails++;
      $error("FAIL t2_long_press_count observed=%0d expected=%0d", lp_cnt, 1);
    end
    key_in[0] = 1'b0;
    cycles(10);

    // 3: short glitch rejected, slightly longer pulse accepted
    key_in[0] = 1'b1; cycles(3);
    key_in[0] = 1'b0; cycles(8);
    key_in[0] = 1'b1; cycles(5);
    key_in[0] = 1'b0; cycles(10);

    // 4: press 20 / release 20
    key_in[0] = 1'b1; cycles(20);
    key_in[0] = 1'b0; cycles(20);

    // 5: clear on the toggle edge, then disabled toggle
    key_in[0] = 1'b1; cycles(5);
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("t5_event_under_clr", ke0, 2'b01);
    chk("t5_led_under_clr", led0, 2'b11);
    key_in[0] = 1'b0; cycles(10);
    led_en = 2'b10;
    key_in[0] = 1'b1; cycles(10);
    key_in[0] = 1'b0; cycles(10);
    led_en = 2'b11;

    // 6: reset mid-debounce with key held
    key_in[0] = 1'b1; cycles(4);
    do_reset();
    cycles(5);
    chk("t6_level_before", kl0, 2'b00);
    cycle();
    chk("t6_level_edge6", kl0, 2'b01);
    chk("t6_event_edge6", ke0, 2'b01);
    key_in = '0; cycles(10);

    // random phase: bursty independent key activity
    for (int i = 0; i < 900; i++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 7) == 0) key_in[k] = ~key_in[k];
      end
      if ($urandom_range(0, 39) == 0) led_en = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 299) == 0) begin
        clr = 1'b0;
        do_reset();
      end else begin
        cycle();
      end
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
